// File: rtl/fft_axis_result_streamer.sv
// Streams the finished FFT result RAM out as one AXI-Stream frame, optionally
// reading in bit-reversed order so the spectrum leaves in natural order.
module fft_axis_result_streamer #(
  parameter int VLW_WDT      = 32,
  parameter int FFT_MEM_SIZE = 1024,
  parameter int ADDR_WDT     = $clog2(FFT_MEM_SIZE),
  parameter int BIT_REV      = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o,
  output logic                mem_rd_en_o,
  output logic [ADDR_WDT-1:0] mem_rd_addr_o,
  input  logic [VLW_WDT-1:0]  mem_rd_data_i,
  output logic [VLW_WDT-1:0]  m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_WDT-1:0] r_rd_idx, r_addr_hold, w_rd_addr;
  logic                r_inflight, r_inflight_last;
  logic [VLW_WDT-1:0]  r_buf_data [2];
  logic [1:0]          r_buf_last;
  logic [1:0]          r_count;
  logic                r_done, r_overrun;
  logic                w_pop, w_push, w_issue, w_rd_last, w_slot;
  logic [2:0]          w_occ;

  generate
    if (BIT_REV != 0) begin : g_rev
      for (genvar gi = 0; gi < ADDR_WDT; gi++) begin : g_bit
        assign w_rd_addr[gi] = r_rd_idx[ADDR_WDT-1-gi];
      end
    end else begin : g_ident
      assign w_rd_addr = r_rd_idx;
    end
  endgenerate

  assign m_axis_tvalid = (r_count != 2'd0);
  assign m_axis_tdata  = r_buf_data[0];
  assign m_axis_tlast  = m_axis_tvalid & r_buf_last[0];
  assign w_pop         = m_axis_tvalid & m_axis_tready;
  assign w_push        = r_inflight;
  // Slots committed after this edge: buffered + in flight, less a same-cycle pop.
  assign w_occ         = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue       = (r_state == S_FETCH) && (w_occ < 3'd2);
  assign w_rd_last     = (r_rd_idx == ADDR_WDT'(FFT_MEM_SIZE - 1));
  // Push lands just behind whatever remains at the head after a possible pop.
  assign w_slot        = (r_count == 2'd1) ? ~w_pop : (r_count == 2'd2);

  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = r_done;
  assign overrun_o     = r_overrun;
  assign mem_rd_en_o   = w_issue;
  assign mem_rd_addr_o = w_issue ? w_rd_addr : r_addr_hold;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_next = S_FETCH;
      S_FETCH: if (w_issue && w_rd_last) w_state_next = S_DRAIN;
      S_DRAIN: if (w_pop && r_buf_last[0]) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_rd_idx        <= '0;
      r_addr_hold     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_buf_data[0]   <= '0;
      r_buf_data[1]   <= '0;
      r_buf_last      <= 2'b00;
      r_count         <= 2'd0;
      r_done          <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_done          <= w_pop & r_buf_last[0];
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_rd_last;
      r_count         <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (start_i && (r_state != S_IDLE))
        r_overrun <= 1'b1;
      if ((r_state == S_IDLE) && start_i)
        r_rd_idx <= '0;
      else if (w_issue)
        r_rd_idx <= r_rd_idx + 1'b1;
      if (w_issue)
        r_addr_hold <= w_rd_addr;
      if (w_pop) begin
        r_buf_data[0] <= r_buf_data[1];
        r_buf_last[0] <= r_buf_last[1];
      end
      if (w_push) begin
        r_buf_data[w_slot] <= mem_rd_data_i;
        r_buf_last[w_slot] <= r_inflight_last;
      end
    end
  end

endmodule

// File: tb/tb_fft_axis_result_streamer.sv
// Directed bench for fft_axis_result_streamer: 16-point bit-reversed frames
// under full-rate, random, stalled, overrun and mid-frame reset traffic.
module tb_fft_axis_result_streamer;
  localparam int N  = 16;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk, rst_n, start_i;
  logic          busy_o, done_o, overrun_o, mem_rd_en_o;
  logic [AW-1:0] mem_rd_addr_o;
  logic [DW-1:0] mem_rd_data_i, m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;

  fft_axis_result_streamer #(.VLW_WDT(DW), .FFT_MEM_SIZE(N), .BIT_REV(1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .overrun_o(overrun_o), .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o),
    .mem_rd_data_i(mem_rd_data_i), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result RAM model with one cycle read latency; RAM[k] = A500_0000 + k.
  logic [DW-1:0] ram [N];
  logic [DW-1:0] ram_q;
  initial for (int k = 0; k < N; k++) ram[k] = 32'hA500_0000 + k;
  initial ram_q = '0;
  always @(posedge clk) if (mem_rd_en_o) ram_q <= ram[mem_rd_addr_o];
  assign mem_rd_data_i = ram_q;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } vec_t;
  vec_t tbl [N];

  int n_cmp = 0;
  int n_bad = 0;
  int n_rd = 0, n_hs = 0, n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reads issued minus beats accepted must never exceed the two buffer slots.
  always @(negedge clk) begin
    if (!rst_n) begin
      n_rd = 0;
      n_hs = 0;
    end else begin
      if (mem_rd_en_o) n_rd++;
      if (m_axis_tvalid && m_axis_tready) n_hs++;
      if (done_o) n_done++;
      if (mem_rd_en_o) check("occupancy", 32'(n_rd - n_hs <= 2), 32'd1);
    end
  end

  task automatic start_frame();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  // mode 0: tready=1, 1: random tready, 2: 20-cycle stall after first tvalid.
  // Returns in the cycle after the final handshake (done cycle), or with
  // rst_n low once abort_beat beats have been accepted.
  task automatic collect(input int mode, input int ovr_beat, input int abort_beat);
    int   beat = 0, t = 0, stall_left = 20, rd0;
    bit   seen_valid = 0, stall_checked = 0;
    logic prev_stall = 0, prev_last = 0;
    logic [DW-1:0] prev_data = '0;
    rd0 = n_rd;
    while (beat < N && t < 300) begin
      if (beat == abort_beat) begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        return;
      end
      seen_valid = seen_valid | m_axis_tvalid;
      case (mode)
        1: m_axis_tready = 1'($urandom_range(0, 1));
        2: begin
          if (seen_valid && stall_left > 0) begin
            m_axis_tready = 1'b0;
            stall_left--;
          end else begin
            if (seen_valid && !stall_checked) begin
              check("stall_reads", 32'(n_rd - rd0), 32'd2);
              stall_checked = 1;
            end
            m_axis_tready = 1'b1;
          end
        end
        default: m_axis_tready = 1'b1;
      endcase
      start_i = (beat == ovr_beat);
      check("done_low", 32'(done_o), 32'd0);
      if (prev_stall) begin
        check("hold_valid", 32'(m_axis_tvalid), 32'd1);
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_last", 32'(m_axis_tlast), 32'(prev_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("tdata", m_axis_tdata, tbl[beat].data);
        check("tlast", 32'(m_axis_tlast), 32'(tbl[beat].last));
        $display("beat %0d tdata=%h tlast=%0d", beat, m_axis_tdata, m_axis_tlast);
        beat++;
        prev_stall = 0;
      end else begin
        prev_stall = m_axis_tvalid;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end
      cyc();
      t++;
    end
    start_i = 1'b0;
    check("frame_beats", 32'(beat), 32'(N));
    if (mode == 2) check("stall_seen", 32'(stall_checked), 32'd1);
    check("done_pulse", 32'(done_o), 32'd1);
    check("busy_after", 32'(busy_o), 32'd0);
    check("valid_after", 32'(m_axis_tvalid), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_overrun"}, 32'(overrun_o), 32'd0);
    check({tag, "_rd_en"}, 32'(mem_rd_en_o), 32'd0);
    check({tag, "_addr"}, 32'(mem_rd_addr_o), 32'd0);
    check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    check({tag, "_tdata"}, m_axis_tdata, 32'd0);
  endtask

  initial begin
    // Bit-reversed 4-bit beat order: 0,8,4,C,2,A,6,E,1,9,5,D,3,B,7,F.
    tbl[0]  = '{32'hA500_0000, 1'b0};
    tbl[1]  = '{32'hA500_0008, 1'b0};
    tbl[2]  = '{32'hA500_0004, 1'b0};
    tbl[3]  = '{32'hA500_000C, 1'b0};
    tbl[4]  = '{32'hA500_0002, 1'b0};
    tbl[5]  = '{32'hA500_000A, 1'b0};
    tbl[6]  = '{32'hA500_0006, 1'b0};
    tbl[7]  = '{32'hA500_000E, 1'b0};
    tbl[8]  = '{32'hA500_0001, 1'b0};
    tbl[9]  = '{32'hA500_0009, 1'b0};
    tbl[10] = '{32'hA500_0005, 1'b0};
    tbl[11] = '{32'hA500_000D, 1'b0};
    tbl[12] = '{32'hA500_0003, 1'b0};
    tbl[13] = '{32'hA500_000B, 1'b0};
    tbl[14] = '{32'hA500_0007, 1'b0};
    tbl[15] = '{32'hA500_000F, 1'b1};

    rst_n = 1'b0;
    start_i = 1'b0;
    m_axis_tready = 1'b0;
    cyc(); cyc(); cyc();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    cyc();

    // Latency: start in cycle 0, reads in cycles 1 and 2, tvalid in cycle 3.
    m_axis_tready = 1'b1;
    start_frame();
    check("c1_busy", 32'(busy_o), 32'd1);
    check("c1_rd_en", 32'(mem_rd_en_o), 32'd1);
    check("c1_addr", 32'(mem_rd_addr_o), 32'd0);
    check("c1_tvalid", 32'(m_axis_tvalid), 32'd0);
    cyc();
    check("c2_rd_en", 32'(mem_rd_en_o), 32'd1);
    check("c2_addr", 32'(mem_rd_addr_o), 32'd8);
    check("c2_tvalid", 32'(m_axis_tvalid), 32'd0);
    cyc();
    check("c3_tvalid", 32'(m_axis_tvalid), 32'd1);
    collect(0, -1, -1);
    check("no_overrun", 32'(overrun_o), 32'd0);

    start_frame();
    collect(1, -1, -1);

    start_frame();
    collect(2, -1, -1);

    // Overrun mid-frame, then a back-to-back frame from the done cycle.
    start_frame();
    collect(0, 5, -1);
    check("overrun_set", 32'(overrun_o), 32'd1);
    start_frame();
    collect(0, -1, -1);
    check("overrun_sticky", 32'(overrun_o), 32'd1);

    // Reset in the middle of a frame abandons it; next frame starts clean.
    start_frame();
    collect(0, -1, 7);
    #1;
    check_idle_outputs("midrst");
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    check("rst_no_done", 32'(n_done), 32'd5);
    start_frame();
    collect(0, -1, -1);
    check("overrun_cleared", 32'(overrun_o), 32'd0);
    cyc();
    check("done_once", 32'(done_o), 32'd0);
    check("done_total", 32'(n_done), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
